// File: rtl/cpu_dump_pkg.sv
// Shared definitions for the halt-triggered data-memory dump engine.
package cpu_dump_pkg;

  localparam int unsigned DUMP_DEPTH     = 1024;
  localparam int unsigned DUMP_ADDR_W    = 10;
  localparam logic [31:0] DUMP_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dump_engine.sv
// On a halt instruction, stalls the CPU and streams every data-memory word
// out over a valid/ready interface, then parks in DONE until reset.
module mem_dump_engine
  import cpu_dump_pkg::*;
#(
  parameter int unsigned DEPTH     = DUMP_DEPTH,
  parameter int unsigned ADDR_W    = DUMP_ADDR_W,
  parameter logic [31:0] HALT_WORD = DUMP_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  output logic              cpu_stall,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              dump_last,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] index_next;
  logic              halt_q;

  // Next-state and word-index update
  always_comb begin
    state_next = state;
    index_next = index;
    unique case (state)
      IDLE: begin
        index_next = '0;
        if (halt_q) state_next = REQ;
      end
      REQ:  state_next = WAIT;
      WAIT: state_next = SEND;
      SEND: begin
        if (dump_ready) begin
          if (index == LAST_IDX) begin
            state_next = DONE;
          end else begin
            index_next = index + ADDR_W'(1);
            state_next = REQ;
          end
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // State, index and registered outputs; outputs follow the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      index       <= '0;
      halt_q      <= 1'b0;
      cpu_stall   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      dump_valid  <= 1'b0;
      dump_data   <= '0;
      dump_addr   <= '0;
      dump_last   <= 1'b0;
      dump_done   <= 1'b0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      halt_q     <= (state == IDLE) && (instruction == HALT_WORD);
      cpu_stall  <= (state_next != IDLE);
      mem_rd_en  <= (state_next == REQ);
      dump_valid <= (state_next == SEND);
      dump_last  <= (state_next == SEND) && (index_next == LAST_IDX);
      dump_done  <= (state_next == DONE);
      if (state_next == REQ) mem_rd_addr <= index_next;
      // Only a read issued in this dump is ever captured
      if (state == WAIT) begin
        dump_data <= mem_rd_data;
        dump_addr <= index;
      end
    end
  end

endmodule
